// File: rtl/pipeline_mem.sv
// rtl/pipeline_mem.sv - memory stage: captures an instruction, runs at most one data-memory access, retires it.
// Loads/stores hold the request until accepted, then wait for the response before retiring.
module pipeline_mem #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] ex_res,
    input  logic [DATA_WIDTH-1:0] r2_val_mem,
    input  logic [4:0]            mem_dst_reg,
    input  logic [31:0]           next_mem_opcode,
    input  logic [2:0]            next_mem_operation_size,
    input  logic                  ecall_mem,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [ADDR_WIDTH-1:0] dmem_req_addr,
    output logic                  dmem_req_we,
    output logic [1:0]            dmem_req_size,
    output logic [DATA_WIDTH-1:0] dmem_req_wdata,
    input  logic                  dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_resp_data,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_val,
    output logic [4:0]            wb_dst_reg,
    output logic                  wb_ecall,
    output logic                  wb_misaligned
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RETIRE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_we_q, req_we_d;
    logic [1:0]            req_size_q, req_size_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [2:0]            ld_size_q, ld_size_d;
    logic [4:0]            dst_q, dst_d;
    logic                  ecall_q, ecall_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_val_q, wb_val_d;
    logic [4:0]            wb_dst_q, wb_dst_d;
    logic                  wb_ecall_q, wb_ecall_d;
    logic                  wb_mis_q, wb_mis_d;

    logic                  cap_is_load, cap_is_store, cap_misaligned;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] resp_ext;

    assign ready          = (state_q == S_IDLE) || (state_q == S_RETIRE);
    assign dmem_req_valid = (state_q == S_REQ);
    assign dmem_req_addr  = req_addr_q;
    assign dmem_req_we    = req_we_q;
    assign dmem_req_size  = req_size_q;
    assign dmem_req_wdata = req_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_val         = wb_val_q;
    assign wb_dst_reg     = wb_dst_q;
    assign wb_ecall       = wb_ecall_q;
    assign wb_misaligned  = wb_mis_q;

    assign cap_is_load  = (next_mem_opcode == 32'd1);
    assign cap_is_store = (next_mem_opcode == 32'd2);

    always_comb begin
        cap_misaligned = 1'b0;
        cap_wdata      = r2_val_mem;
        case (next_mem_operation_size[1:0])
            2'd0: begin
                cap_misaligned = 1'b0;
                cap_wdata      = {{(DATA_WIDTH-8){1'b0}}, r2_val_mem[7:0]};
            end
            2'd1: begin
                cap_misaligned = ex_res[0];
                cap_wdata      = {{(DATA_WIDTH-16){1'b0}}, r2_val_mem[15:0]};
            end
            2'd2: begin
                cap_misaligned = |ex_res[1:0];
                cap_wdata      = {{(DATA_WIDTH-32){1'b0}}, r2_val_mem[31:0]};
            end
            default: begin
                cap_misaligned = |ex_res[2:0];
                cap_wdata      = r2_val_mem;
            end
        endcase
    end

    // Extension fill bit is forced to 0 for unsigned loads (size[2]).
    always_comb begin
        resp_ext = dmem_resp_data;
        case (ld_size_q[1:0])
            2'd0:    resp_ext = {{(DATA_WIDTH-8){~ld_size_q[2] & dmem_resp_data[7]}}, dmem_resp_data[7:0]};
            2'd1:    resp_ext = {{(DATA_WIDTH-16){~ld_size_q[2] & dmem_resp_data[15]}}, dmem_resp_data[15:0]};
            2'd2:    resp_ext = {{(DATA_WIDTH-32){~ld_size_q[2] & dmem_resp_data[31]}}, dmem_resp_data[31:0]};
            default: resp_ext = dmem_resp_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_size_d  = req_size_q;
        req_wdata_d = req_wdata_q;
        ld_size_d   = ld_size_q;
        dst_d       = dst_q;
        ecall_d     = ecall_q;
        wb_valid_d  = 1'b0;
        wb_val_d    = wb_val_q;
        wb_dst_d    = wb_dst_q;
        wb_ecall_d  = wb_ecall_q;
        wb_mis_d    = wb_mis_q;
        case (state_q)
            S_REQ: begin
                if (dmem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_resp_valid) begin
                    state_d    = S_RETIRE;
                    wb_valid_d = 1'b1;
                    wb_val_d   = req_we_q ? '0 : resp_ext;
                    wb_dst_d   = req_we_q ? 5'd0 : dst_q;
                    wb_ecall_d = ecall_q;
                    wb_mis_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (in_valid) begin
                    wb_ecall_d = ecall_mem;
                    ecall_d    = ecall_mem;
                    if ((cap_is_load || cap_is_store) && cap_misaligned) begin
                        state_d    = S_RETIRE;
                        wb_valid_d = 1'b1;
                        wb_val_d   = '0;
                        wb_dst_d   = 5'd0;
                        wb_mis_d   = 1'b1;
                    end else if (cap_is_load || cap_is_store) begin
                        state_d     = S_REQ;
                        req_addr_d  = ex_res[ADDR_WIDTH-1:0];
                        req_we_d    = cap_is_store;
                        req_size_d  = next_mem_operation_size[1:0];
                        req_wdata_d = cap_wdata;
                        ld_size_d   = next_mem_operation_size;
                        dst_d       = mem_dst_reg;
                    end else begin
                        state_d    = S_RETIRE;
                        wb_valid_d = 1'b1;
                        wb_val_d   = ex_res;
                        wb_dst_d   = mem_dst_reg;
                        wb_mis_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_size_q  <= 2'd0;
            req_wdata_q <= '0;
            ld_size_q   <= 3'd0;
            dst_q       <= 5'd0;
            ecall_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_val_q    <= '0;
            wb_dst_q    <= 5'd0;
            wb_ecall_q  <= 1'b0;
            wb_mis_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_size_q  <= req_size_d;
            req_wdata_q <= req_wdata_d;
            ld_size_q   <= ld_size_d;
            dst_q       <= dst_d;
            ecall_q     <= ecall_d;
            wb_valid_q  <= wb_valid_d;
            wb_val_q    <= wb_val_d;
            wb_dst_q    <= wb_dst_d;
            wb_ecall_q  <= wb_ecall_d;
            wb_mis_q    <= wb_mis_d;
        end
    end

endmodule

// File: tb/tb_pipeline_mem.sv
// tb/tb_pipeline_mem.sv - directed and randomized checks of pipeline_mem against a behavioural model.
module tb_pipeline_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        in_valid;
    logic [63:0] ex_res;
    logic [63:0] r2_val_mem;
    logic [4:0]  mem_dst_reg;
    logic [31:0] next_mem_opcode;
    logic [2:0]  next_mem_operation_size;
    logic        ecall_mem;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [1:0]  dmem_req_size;
    logic [63:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_data;
    logic        wb_valid;
    logic [63:0] wb_val;
    logic [4:0]  wb_dst_reg;
    logic        wb_ecall;
    logic        wb_misaligned;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .ready(ready), .in_valid(in_valid),
        .ex_res(ex_res), .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
        .next_mem_opcode(next_mem_opcode), .next_mem_operation_size(next_mem_operation_size),
        .ecall_mem(ecall_mem), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we), .dmem_req_size(dmem_req_size),
        .dmem_req_wdata(dmem_req_wdata), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data(dmem_resp_data), .wb_valid(wb_valid), .wb_val(wb_val),
        .wb_dst_reg(wb_dst_reg), .wb_ecall(wb_ecall), .wb_misaligned(wb_misaligned)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        int bits;
        bits = 8 << sz;
        if (bits == 64) return '1;
        return (64'd1 << bits) - 64'd1;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] data, input logic [2:0] sz);
        logic [63:0] v;
        int bits;
        bits = 8 << sz[1:0];
        v = data & size_mask(sz[1:0]);
        if (bits < 64 && !sz[2] && v[bits-1]) v = v | ~size_mask(sz[1:0]);
        return v;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Issue one instruction from an idle stage and follow it through to retire.
    task automatic run_instr(input logic [31:0] op, input logic [2:0] sz, input logic [63:0] ex,
                             input logic [63:0] r2, input logic [4:0] dst, input logic ec,
                             input int stall, input int waitc, input logic [63:0] rdata);
        logic is_mem, is_load, mis;
        logic [63:0] bytes;
        bytes   = 64'd1 << sz[1:0];
        is_load = (op == 32'd1);
        is_mem  = (op == 32'd1) || (op == 32'd2);
        mis     = is_mem && ((ex % bytes) != 64'd0);
        @(negedge clk);
        check("ready_before", ready, 1'b1);
        in_valid = 1'b1; ex_res = ex; r2_val_mem = r2; mem_dst_reg = dst;
        next_mem_opcode = op; next_mem_operation_size = sz; ecall_mem = ec;
        @(negedge clk);
        in_valid = 1'b0; ex_res = ~ex; r2_val_mem = ~r2; mem_dst_reg = ~dst;
        next_mem_operation_size = ~sz; ecall_mem = ~ec;
        if (!is_mem || mis) begin
            check("fast_wb_valid", wb_valid, 1'b1);
            check("fast_wb_val", wb_val, mis ? 64'd0 : ex);
            check("fast_wb_dst", wb_dst_reg, mis ? 5'd0 : dst);
            check("fast_wb_mis", wb_misaligned, mis);
            check("fast_wb_ecall", wb_ecall, ec);
            check("fast_no_req", dmem_req_valid, 1'b0);
            check("fast_ready", ready, 1'b1);
        end else begin
            for (int s = 0; s <= stall; s++) begin
                check("req_valid", dmem_req_valid, 1'b1);
                check("req_addr", dmem_req_addr, ex);
                check("req_we", dmem_req_we, op == 32'd2);
                check("req_size", dmem_req_size, sz[1:0]);
                check("req_wdata", dmem_req_wdata, r2 & size_mask(sz[1:0]));
                check("req_ready_low", ready, 1'b0);
                check("req_no_wb", wb_valid, 1'b0);
                dmem_resp_valid = 1'b1;
                dmem_resp_data  = rnd64();
                dmem_req_ready  = (s == stall);
                @(negedge clk);
            end
            dmem_req_ready  = 1'b0;
            dmem_resp_valid = 1'b0;
            check("wait_req_valid", dmem_req_valid, 1'b0);
            check("wait_ready", ready, 1'b0);
            check("wait_no_wb", wb_valid, 1'b0);
            for (int w = 0; w < waitc; w++) begin
                @(negedge clk);
                check("wait_hold_no_wb", wb_valid, 1'b0);
                check("wait_hold_no_req", dmem_req_valid, 1'b0);
            end
            dmem_resp_valid = 1'b1;
            dmem_resp_data  = rdata;
            @(negedge clk);
            dmem_resp_valid = 1'b0;
            check("mem_wb_valid", wb_valid, 1'b1);
            check("mem_wb_val", wb_val, is_load ? model_load(rdata, sz) : 64'd0);
            check("mem_wb_dst", wb_dst_reg, is_load ? dst : 5'd0);
            check("mem_wb_ecall", wb_ecall, ec);
            check("mem_wb_mis", wb_misaligned, 1'b0);
            check("mem_ready", ready, 1'b1);
        end
        @(negedge clk);
        check("wb_pulse_end", wb_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; ex_res = 64'd9; r2_val_mem = '0; mem_dst_reg = 5'd4;
        next_mem_opcode = '0; next_mem_operation_size = '0; ecall_mem = 1'b1;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_val", wb_val, 64'd0);
        check("rst_wb_dst", wb_dst_reg, 5'd0);
        check("rst_wb_ecall", wb_ecall, 1'b0);
        check("rst_wb_mis", wb_misaligned, 1'b0);
        check("rst_req_valid", dmem_req_valid, 1'b0);
        check("rst_req_addr", dmem_req_addr, 64'd0);
        check("rst_req_wdata", dmem_req_wdata, 64'd0);
        check("rst_req_size", dmem_req_size, 2'd0);
        check("rst_req_we", dmem_req_we, 1'b0);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_no_capture", wb_valid, 1'b0);
        check("post_rst_ready", ready, 1'b1);

        // Three back-to-back ALU pass-throughs.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                check("b2b_wb_valid", wb_valid, 1'b1);
                check("b2b_wb_val", wb_val, 64'(4 + i));
                check("b2b_wb_dst", wb_dst_reg, 5'(i));
            end
            check("b2b_ready", ready, 1'b1);
            in_valid = (i < 3); ex_res = 64'(5 + i); mem_dst_reg = 5'(i + 1);
            next_mem_opcode = 32'd0; next_mem_operation_size = 3'd3; ecall_mem = 1'b0;
            @(negedge clk);
        end
        check("b2b_end", wb_valid, 1'b0);

        run_instr(32'd1, 3'd0, 64'h1003, 64'd0, 5'd7, 1'b0, 2, 0, 64'h80);
        run_instr(32'd1, 3'd5, 64'h100, 64'd0, 5'd8, 1'b1, 0, 1, 64'hFFFF_8001);
        run_instr(32'd2, 3'd2, 64'h2000, 64'hDEAD_BEEF_1234_5678, 5'd9, 1'b0, 1, 2, 64'd0);
        run_instr(32'd1, 3'd3, 64'h1004, 64'd0, 5'd10, 1'b0, 0, 0, 64'd0);
        run_instr(32'd1, 3'd2, 64'h3000, 64'd0, 5'd0, 1'b0, 0, 0, 64'h8765_4321);
        run_instr(32'd7, 3'd1, 64'h1235, 64'd0, 5'd11, 1'b1, 0, 0, 64'd0);

        // Reset while waiting for the response; the late response must be ignored.
        @(negedge clk);
        in_valid = 1'b1; ex_res = 64'h4000; mem_dst_reg = 5'd12;
        next_mem_opcode = 32'd1; next_mem_operation_size = 3'd3; ecall_mem = 1'b0;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rw_req_valid", dmem_req_valid, 1'b1);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        check("rw_in_wait", dmem_req_valid, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dmem_resp_valid = 1'b1; dmem_resp_data = 64'h55;
        check("rw_ready_after_rst", ready, 1'b1);
        check("rw_no_wb", wb_valid, 1'b0);
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        check("rw_late_resp_no_wb", wb_valid, 1'b0);
        check("rw_idle_ready", ready, 1'b1);
        check("rw_no_req", dmem_req_valid, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] op;
            logic [2:0]  sz;
            logic [63:0] ex;
            case ($urandom_range(0, 3))
                0: op = 32'd0;
                1: op = 32'd1;
                2: op = 32'd2;
                default: op = 32'd3 + 32'($urandom_range(0, 1000));
            endcase
            sz = 3'($urandom_range(0, 7));
            ex = rnd64();
            if ($urandom_range(0, 3) != 0) ex = ex & ~((64'd1 << sz[1:0]) - 64'd1);
            run_instr(op, sz, ex, rnd64(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), rnd64());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
